// File: rtl/key_step_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : key_step_pulse
//  Purpose  : Debounces one raw push-button and produces single-cycle step
//             pulses for the add_flag input of the 7-segment display stage.
//             Each accepted press gives one pulse. While the key is held,
//             pulses auto-repeat: the first repeat comes REPEAT_DELAY cycles
//             after the press pulse, then one every REPEAT_RATE cycles.
//  Ports    : clk           - system clock, sole clock domain
//             rst           - synchronous active-high reset
//             key_in        - raw, asynchronous, bouncing key pin
//             step_flag     - one-cycle pulse per accepted press / repeat
//             key_level     - debounced key level, 1 = pressed
//             repeat_active - high while the key is in auto-repeat
//  Revision : 1.0 - initial release
// ============================================================================
module key_step_pulse #(
   parameter int               CNT_W        = 25,
   parameter logic [CNT_W-1:0] DEBOUNCE_CNT = 25'd1_000_000,
   parameter logic [CNT_W-1:0] REPEAT_DELAY = 25'd25_000_000,
   parameter logic [CNT_W-1:0] REPEAT_RATE  = 25'd5_000_000,
   parameter logic             REPEAT_EN    = 1'b1,
   parameter logic             KEY_ACTIVE   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic step_flag,
   output logic key_level,
   output logic repeat_active
);

   // Terminal counts: a phase lasting N cycles ends when the counter reads N-1.
   localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
   localparam logic [CNT_W-1:0] c_RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] c_RR_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRESS_DB = 3'd1,
      ST_HELD     = 3'd2,
      ST_REPEAT   = 3'd3,
      ST_REL_DB   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_step;
   logic             w_step_nxt;
   logic             r_level;
   logic             w_level_nxt;
   logic             r_rep;
   logic             w_rep_nxt;
   logic             r_sync1;
   logic             r_sync2;
   logic             w_pressed;

   // Two-flop synchroniser; reset loads the "released" level so a key held
   // through reset is seen as a fresh press.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= ~KEY_ACTIVE;
         r_sync2 <= ~KEY_ACTIVE;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_pressed = (r_sync2 == KEY_ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_step  <= 1'b0;
         r_level <= 1'b0;
         r_rep   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_step  <= w_step_nxt;
         r_level <= w_level_nxt;
         r_rep   <= w_rep_nxt;
      end
   end

   // Every state change clears the counter; within a state it counts up to
   // its terminal value, so it can never wrap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_step_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_pressed) begin
               w_state_nxt = ST_PRESS_DB;
            end
         end

         ST_PRESS_DB: begin
            if (!w_pressed) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_DB_LAST) begin
               w_state_nxt = ST_HELD;
               w_cnt_nxt   = '0;
               w_step_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         ST_HELD: begin
            // Release is checked first so it wins over a coincident repeat.
            if (!w_pressed) begin
               w_state_nxt = ST_REL_DB;
               w_cnt_nxt   = '0;
            end else if (REPEAT_EN && (r_cnt == c_RD_LAST)) begin
               w_state_nxt = ST_REPEAT;
               w_cnt_nxt   = '0;
               w_step_nxt  = 1'b1;
            end else if (r_cnt != c_CNT_MAX) begin
               // Saturates when repeat is disabled and the key is held forever.
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         ST_REPEAT: begin
            if (!w_pressed) begin
               w_state_nxt = ST_REL_DB;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_RR_LAST) begin
               w_cnt_nxt  = '0;
               w_step_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         ST_REL_DB: begin
            // A re-press here only restarts the release window; the earlier
            // repeat timing is dropped and no pulse is produced.
            if (w_pressed) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == c_DB_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Level outputs follow the state being entered, so they are registered
      // alongside it.
      w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REPEAT) ||
                    (w_state_nxt == ST_REL_DB);
      w_rep_nxt   = (w_state_nxt == ST_REPEAT);
   end

   assign step_flag     = r_step;
   assign key_level     = r_level;
   assign repeat_active = r_rep;

endmodule
`default_nettype wire

// File: tb/tb_key_step_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_step_pulse
//  Purpose  : Self-checking bench for key_step_pulse. Two instances share
//             clock, reset and key: dut_a with auto-repeat, dut_b without.
//             Pulse positions are recorded as a bit mask indexed by the clock
//             edge (edge 0 = first edge that samples the new key level) and
//             compared with hand-computed masks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_step_pulse;

   logic clk = 1'b0;
   logic rst;
   logic key_in;
   logic step_a, level_a, rep_a;
   logic step_b, level_b, rep_b;

   int n_cmp = 0;
   int n_err = 0;

   logic [127:0] mask_a, mask_b, exp_m;
   logic         ra_seen_a, ra_seen_b;
   logic         prev_a, prev_b;
   int           consec = 0;
   int           ed;

   always #5 clk = ~clk;

   key_step_pulse #(
      .CNT_W(25), .DEBOUNCE_CNT(25'd4), .REPEAT_DELAY(25'd20),
      .REPEAT_RATE(25'd8), .REPEAT_EN(1'b1), .KEY_ACTIVE(1'b0)
   ) dut_a (
      .clk(clk), .rst(rst), .key_in(key_in),
      .step_flag(step_a), .key_level(level_a), .repeat_active(rep_a)
   );

   key_step_pulse #(
      .CNT_W(25), .DEBOUNCE_CNT(25'd4), .REPEAT_DELAY(25'd20),
      .REPEAT_RATE(25'd8), .REPEAT_EN(1'b0), .KEY_ACTIVE(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst), .key_in(key_in),
      .step_flag(step_b), .key_level(level_b), .repeat_active(rep_b)
   );

   task automatic check_eq(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge, sample 1 time unit later, record pulses at index ed.
   task automatic adv();
      @(posedge clk);
      #1;
      if (ed < 128) begin
         mask_a[ed] = step_a;
         mask_b[ed] = step_b;
      end
      if ((step_a && prev_a) || (step_b && prev_b)) consec++;
      prev_a = step_a;
      prev_b = step_b;
      if (rep_a) ra_seen_a = 1'b1;
      if (rep_b) ra_seen_b = 1'b1;
      ed++;
   endtask

   task automatic clear_rec();
      mask_a    = '0;
      mask_b    = '0;
      ra_seen_a = 1'b0;
      ra_seen_b = 1'b0;
      ed        = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      prev_a = 1'b0;
      prev_b = 1'b0;
      rst    = 1'b1;
      key_in = 1'b1;
      clear_rec();
      repeat (3) adv();
      check_eq("reset_outs_a", {step_a, level_a, rep_a}, 3'b000);
      check_eq("reset_outs_b", {step_b, level_b, rep_b}, 3'b000);
      rst = 1'b0;
      repeat (5) adv();

      // 1: clean press for 10 cycles, then release
      clear_rec();
      for (int e = 0; e < 26; e++) begin
         key_in = (e < 10) ? 1'b0 : 1'b1;
         adv();
         if (e == 5)  check_eq("t1_level_e5",  level_a, 1'b0);
         if (e == 6)  check_eq("t1_level_e6",  level_a, 1'b1);
         if (e == 15) check_eq("t1_level_e15", level_a, 1'b1);
         if (e == 16) check_eq("t1_level_e16", level_a, 1'b0);
      end
      exp_m = '0; exp_m[6] = 1'b1;
      check_eq("t1_pulses_a", mask_a, exp_m);
      check_eq("t1_pulses_b", mask_b, exp_m);

      // 2: bounce, 2-cycle toggles for 20 cycles, then released
      clear_rec();
      for (int e = 0; e < 30; e++) begin
         key_in = (e < 20) ? (((e / 2) % 2) != 0) : 1'b1;
         adv();
      end
      check_eq("t2_pulses_a", mask_a, 128'd0);
      check_eq("t2_pulses_b", mask_b, 128'd0);
      check_eq("t2_level_rep", {level_a, rep_a}, 2'b00);

      // 3: long hold, 60 cycles
      clear_rec();
      for (int e = 0; e < 64; e++) begin
         key_in = (e < 60) ? 1'b0 : 1'b1;
         adv();
         if (e == 25) check_eq("t3_rep_e25", rep_a, 1'b0);
         if (e == 26) check_eq("t3_rep_e26", rep_a, 1'b1);
      end
      exp_m = '0;
      exp_m[6] = 1'b1; exp_m[26] = 1'b1; exp_m[34] = 1'b1;
      exp_m[42] = 1'b1; exp_m[50] = 1'b1; exp_m[58] = 1'b1;
      check_eq("t3_pulses_a", mask_a, exp_m);
      exp_m = '0; exp_m[6] = 1'b1;
      check_eq("t3_pulses_b", mask_b, exp_m);
      check_eq("t3_rep_seen_b", ra_seen_b, 1'b0);
      key_in = 1'b1;
      repeat (8) adv();
      check_eq("t3_level_after_rel", level_a, 1'b0);

      // 4: release glitch during HELD, key pressed again and held
      clear_rec();
      for (int e = 0; e < 41; e++) begin
         key_in = (e == 10 || e == 11) ? 1'b1 : 1'b0;
         adv();
         if (e == 12) check_eq("t4_level_e12", level_a, 1'b1);
      end
      exp_m = '0; exp_m[6] = 1'b1;
      check_eq("t4_pulses_a", mask_a, exp_m);
      check_eq("t4_level_e40", level_a, 1'b1);
      check_eq("t4_rep_seen_a", ra_seen_a, 1'b0);
      key_in = 1'b1;
      repeat (8) adv();
      check_eq("t4_level_after_rel", level_a, 1'b0);

      // 5: reset at edge 30 while repeating, key still held
      clear_rec();
      for (int e = 0; e < 51; e++) begin
         key_in = 1'b0;
         rst    = (e == 30);
         adv();
         if (e == 29) check_eq("t5_rep_e29", rep_a, 1'b1);
         if (e == 30) check_eq("t5_outs_after_rst", {step_a, level_a, rep_a}, 3'b000);
      end
      rst = 1'b0;
      exp_m = '0; exp_m[6] = 1'b1; exp_m[26] = 1'b1; exp_m[37] = 1'b1;
      check_eq("t5_pulses_a", mask_a, exp_m);
      key_in = 1'b1;
      repeat (10) adv();
      check_eq("t5_level_after_rel", level_a, 1'b0);

      // 6: 100-cycle hold; dut_b (no repeat) must pulse exactly once
      clear_rec();
      for (int e = 0; e < 110; e++) begin
         key_in = (e < 100) ? 1'b0 : 1'b1;
         adv();
      end
      exp_m = '0; exp_m[6] = 1'b1;
      check_eq("t6_pulses_b", mask_b, exp_m);
      check_eq("t6_rep_seen_b", ra_seen_b, 1'b0);
      for (int k = 26; k < 100; k += 8) exp_m[k] = 1'b1;
      check_eq("t6_pulses_a", mask_a, exp_m);
      check_eq("t6_level_b_end", level_b, 1'b0);

      check_eq("no_back_to_back", consec, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
